// File: rtl/sin_phase_gen.sv
// Phase accumulator (NCO) front end producing the PHASE_W-bit phase word for the sin stage.
// Free-running or N-sample burst operation, configured through a valid/ready handshake.
module sin_phase_gen #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 14,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ACC_W-1:0]   cfg_fcw,
    input  logic [PHASE_W-1:0] cfg_ofs,
    input  logic               cfg_burst,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_clr,
    input  logic               stop,
    output logic [PHASE_W-1:0] x,
    output logic               x_valid,
    input  logic               x_ready,
    output logic               busy,
    output logic               done
);

    // state | meaning
    // IDLE  | waiting for configuration, no samples offered
    // RUN   | offering phase samples downstream
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [ACC_W-1:0]   fcw_r, fcw_nxt;
    logic [PHASE_W-1:0] ofs_r, ofs_nxt;
    logic               burst_r, burst_nxt;
    logic [LEN_W-1:0]   len_r, len_nxt;
    logic [LEN_W-1:0]   count, count_nxt;
    logic [PHASE_W-1:0] x_nxt;
    logic               x_valid_nxt;
    logic               done_nxt;

    logic [ACC_W-1:0]   acc_sel;
    logic [ACC_W-1:0]   acc_inc;
    logic               xfer;
    logic               last;

    assign acc_sel = cfg_clr ? '0 : acc;
    assign acc_inc = acc + fcw_r;
    assign xfer    = x_valid & x_ready;
    // Only meaningful in burst mode, where len_r is known to be non-zero.
    assign last    = burst_r && (count == len_r - LEN_W'(1));

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        fcw_nxt     = fcw_r;
        ofs_nxt     = ofs_r;
        burst_nxt   = burst_r;
        len_nxt     = len_r;
        count_nxt   = count;
        x_nxt       = x;
        x_valid_nxt = x_valid;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                x_valid_nxt = 1'b0;
                if (cfg_valid) begin
                    fcw_nxt   = cfg_fcw;
                    ofs_nxt   = cfg_ofs;
                    burst_nxt = cfg_burst;
                    len_nxt   = cfg_len;
                    acc_nxt   = acc_sel;
                    count_nxt = '0;
                    if (cfg_burst && (cfg_len == '0)) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt   = RUN;
                        x_valid_nxt = 1'b1;
                        x_nxt       = acc_sel[ACC_W-1 -: PHASE_W] + cfg_ofs;
                    end
                end
            end

            RUN: begin
                if (xfer) begin
                    acc_nxt = acc_inc;
                    if (count != '1) begin
                        count_nxt = count + LEN_W'(1);
                    end
                    if (last) begin
                        // A completed burst wins over a coincident stop.
                        state_nxt   = IDLE;
                        x_valid_nxt = 1'b0;
                        done_nxt    = 1'b1;
                    end else if (stop) begin
                        state_nxt   = IDLE;
                        x_valid_nxt = 1'b0;
                    end else begin
                        x_nxt = acc_inc[ACC_W-1 -: PHASE_W] + ofs_r;
                    end
                end else if (stop) begin
                    state_nxt   = IDLE;
                    x_valid_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt   = IDLE;
                x_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            fcw_r   <= '0;
            ofs_r   <= '0;
            burst_r <= 1'b0;
            len_r   <= '0;
            count   <= '0;
            x       <= '0;
            x_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            fcw_r   <= fcw_nxt;
            ofs_r   <= ofs_nxt;
            burst_r <= burst_nxt;
            len_r   <= len_nxt;
            count   <= count_nxt;
            x       <= x_nxt;
            x_valid <= x_valid_nxt;
            done    <= done_nxt;
        end
    end

    assign cfg_ready = (state == IDLE);
    assign busy      = (state == RUN);

endmodule
